// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the pipeline control logic and pipeline_stall_ctrl.
//   master : hazard/memory sources (drives the *_i flags, observes enables/flushes)
//   slave  : pipeline_stall_ctrl (consumes the flags, drives enables/flushes/counters)
// Signals:
//   start_i, LoadUse_i, Branch_Taken_i, DMem_Req_i, DMem_Hit_i, DMem_Ack_i : inputs to the sequencer
//   PC_En_o, IFID_En_o, IFID_Flush_o, IDEX_Flush_o, EXMEM_En_o, MEMWB_Flush_o : per-stage controls
//   Busy_o, Error_o                                                         : status
//   Stall_Cnt_o, Flush_Cnt_o                                                : saturating perf counters
interface pipeline_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start_i;
  logic             LoadUse_i;
  logic             Branch_Taken_i;
  logic             DMem_Req_i;
  logic             DMem_Hit_i;
  logic             DMem_Ack_i;
  logic             PC_En_o;
  logic             IFID_En_o;
  logic             IFID_Flush_o;
  logic             IDEX_Flush_o;
  logic             EXMEM_En_o;
  logic             MEMWB_Flush_o;
  logic             Busy_o;
  logic             Error_o;
  logic [CNT_W-1:0] Stall_Cnt_o;
  logic [CNT_W-1:0] Flush_Cnt_o;

  modport master (
    output start_i, LoadUse_i, Branch_Taken_i, DMem_Req_i, DMem_Hit_i, DMem_Ack_i,
    input  PC_En_o, IFID_En_o, IFID_Flush_o, IDEX_Flush_o, EXMEM_En_o, MEMWB_Flush_o,
    input  Busy_o, Error_o, Stall_Cnt_o, Flush_Cnt_o
  );

  modport slave (
    input  start_i, LoadUse_i, Branch_Taken_i, DMem_Req_i, DMem_Hit_i, DMem_Ack_i,
    output PC_En_o, IFID_En_o, IFID_Flush_o, IDEX_Flush_o, EXMEM_En_o, MEMWB_Flush_o,
    output Busy_o, Error_o, Stall_Cnt_o, Flush_Cnt_o
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges load-use hazard, ID-stage taken branch and data-memory miss handshake into
// per-stage enables/flushes, freezes PC..EX/MEM across a memory miss, and keeps
// saturating stall/flush cycle counters.
// Ports:
//   clk_i : clock, all state on rising edge
//   rst_i : synchronous active-high reset
//   bus   : pipeline_stall_ctrl_if slave modport (hazard inputs, stage controls, counters)
// Parameters:
//   CNT_W        : width of the stall/flush counters (saturating)
//   MISS_TIMEOUT : MEM_WAIT cycles without ack before ERROR (>= 1)
module pipeline_stall_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MISS_TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipeline_stall_ctrl_if.slave bus
);
  localparam int unsigned          TMO_W    = $clog2(MISS_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(MISS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_MEM_WAIT,
    S_ERROR
  } state_t;

  state_t           state_q, state_nxt;
  logic [TMO_W-1:0] tmo_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic freeze, eval_run;
  logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_flush, busy, error;
  logic stall_inc;

  // The miss/wait cycles share one "freeze" output set; RUN and the MEM_WAIT
  // release cycle share one hazard evaluation, so the case only classifies.
  always_comb begin
    state_nxt = state_q;
    freeze    = 1'b0;
    eval_run  = 1'b0;
    busy      = 1'b0;
    error     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.DMem_Req_i && !bus.DMem_Hit_i) begin
          freeze    = 1'b1;
          state_nxt = S_MEM_WAIT;
        end else begin
          eval_run = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        busy = 1'b1;
        if (bus.DMem_Ack_i) begin
          eval_run  = 1'b1;
          state_nxt = S_RUN;
        end else begin
          freeze = 1'b1;
          if (tmo_q == TMO_LAST) state_nxt = S_ERROR;
        end
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    memwb_flush = 1'b0;
    if (freeze) begin
      memwb_flush = 1'b1;
    end else if (eval_run) begin
      exmem_en = 1'b1;
      if (bus.LoadUse_i) begin
        idex_flush = 1'b1;
      end else begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = bus.Branch_Taken_i;
      end
    end
  end

  assign stall_inc = (state_q == S_RUN || state_q == S_MEM_WAIT) && !pc_en;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == S_MEM_WAIT && !bus.DMem_Ack_i) tmo_q <= tmo_q + 1'b1;
      else                                          tmo_q <= '0;
      if (stall_inc && stall_cnt_q != '1)  stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ifid_flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.PC_En_o       = pc_en;
  assign bus.IFID_En_o     = ifid_en;
  assign bus.IFID_Flush_o  = ifid_flush;
  assign bus.IDEX_Flush_o  = idex_flush;
  assign bus.EXMEM_En_o    = exmem_en;
  assign bus.MEMWB_Flush_o = memwb_flush;
  assign bus.Busy_o        = busy;
  assign bus.Error_o       = error;
  assign bus.Stall_Cnt_o   = stall_cnt_q;
  assign bus.Flush_Cnt_o   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;
  localparam int unsigned CNT_W = 3;

  // Flag order: {PC_En, IFID_En, IFID_Flush, IDEX_Flush, EXMEM_En, MEMWB_Flush, Busy, Error}
  localparam logic [7:0] IDLE_O = 8'b0000_0000;
  localparam logic [7:0] RUN_O  = 8'b1100_1000;
  localparam logic [7:0] LU_O   = 8'b0001_1000;
  localparam logic [7:0] BR_O   = 8'b1110_1000;
  localparam logic [7:0] MISS_O = 8'b0000_0100;
  localparam logic [7:0] WAIT_O = 8'b0000_0110;
  localparam logic [7:0] REL_O  = 8'b1100_1010;
  localparam logic [7:0] RELB_O = 8'b1110_1010;
  localparam logic [7:0] RELL_O = 8'b0001_1010;
  localparam logic [7:0] ERR_O  = 8'b0000_0001;

  typedef struct {
    logic       chk;
    logic [7:0] flags;
    int         s;
    int         f;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(
    .CNT_W       (CNT_W),
    .MISS_TIMEOUT(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs just after the edge and queue what the DUT must show.
  task automatic step(input logic r, input logic st, input logic lu, input logic br,
                      input logic rq, input logic ht, input logic ak,
                      input logic ck, input logic [7:0] fl, input int s, input int f);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i              = r;
    bus.start_i        = st;
    bus.LoadUse_i      = lu;
    bus.Branch_Taken_i = br;
    bus.DMem_Req_i     = rq;
    bus.DMem_Hit_i     = ht;
    bus.DMem_Ack_i     = ak;
    e.chk   = ck;
    e.flags = fl;
    e.s     = s;
    e.f     = f;
    sb.push_back(e);
  endtask

  task automatic none(input logic [7:0] fl, input int s, input int f);
    step(0, 0, 0, 0, 0, 0, 0, 1, fl, s, f);
  endtask

  // Reset cycle (unchecked), then the IDLE cycle with start_i=1; ends in RUN with counters 0.
  task automatic reset_start();
    step(1, 0, 0, 0, 0, 0, 0, 0, IDLE_O, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, IDLE_O, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle; sample mid-cycle on the falling edge.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk_i);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          act = {bus.PC_En_o, bus.IFID_En_o, bus.IFID_Flush_o, bus.IDEX_Flush_o,
                 bus.EXMEM_En_o, bus.MEMWB_Flush_o, bus.Busy_o, bus.Error_o};
          total++;
          if (act !== e.flags) begin
            bad++;
            $display("FAIL flags t=%0t actual=%b required=%b", $time, act, e.flags);
          end
          total++;
          if (bus.Stall_Cnt_o !== CNT_W'(e.s)) begin
            bad++;
            $display("FAIL stall_cnt t=%0t actual=%0d required=%0d", $time, bus.Stall_Cnt_o, e.s);
          end
          total++;
          if (bus.Flush_Cnt_o !== CNT_W'(e.f)) begin
            bad++;
            $display("FAIL flush_cnt t=%0t actual=%0d required=%0d", $time, bus.Flush_Cnt_o, e.f);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 0; bus.LoadUse_i = 0; bus.Branch_Taken_i = 0;
    bus.DMem_Req_i = 0; bus.DMem_Hit_i = 0; bus.DMem_Ack_i = 0;

    // Reset state, start_i low stays idle, then start and free-running
    step(1, 0, 0, 0, 0, 0, 0, 0, IDLE_O, 0, 0);
    none(IDLE_O, 0, 0);
    none(IDLE_O, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, IDLE_O, 0, 0);
    for (int i = 0; i < 5; i++) none(RUN_O, 0, 0);

    // Load-use beats branch; branch alone flushes IF/ID; hit, stray ack, hit without req ignored
    step(0, 0, 1, 1, 0, 0, 0, 1, LU_O, 0, 0);
    none(RUN_O, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 1, BR_O, 1, 0);
    none(RUN_O, 1, 1);
    step(0, 0, 0, 0, 1, 1, 0, 1, RUN_O, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1, RUN_O, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0, 1, RUN_O, 1, 1);

    // Miss, three waits, release with no hazard
    reset_start();
    step(0, 0, 0, 0, 1, 0, 0, 1, MISS_O, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, WAIT_O, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, WAIT_O, 2, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, WAIT_O, 3, 0);
    step(0, 0, 0, 0, 1, 0, 1, 1, REL_O, 4, 0);
    none(RUN_O, 4, 0);

    // Release cycle evaluates branch / load-use; miss outranks both hazards
    reset_start();
    step(0, 0, 0, 0, 1, 0, 0, 1, MISS_O, 0, 0);
    step(0, 0, 0, 1, 1, 0, 1, 1, RELB_O, 1, 0);
    none(RUN_O, 1, 1);
    step(0, 0, 0, 0, 1, 0, 0, 1, MISS_O, 1, 1);
    step(0, 0, 1, 0, 1, 0, 1, 1, RELL_O, 2, 1);
    none(RUN_O, 3, 1);
    step(0, 0, 1, 1, 1, 0, 0, 1, MISS_O, 3, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1, REL_O, 4, 1);
    none(RUN_O, 4, 1);

    // Ack on the last allowed wait cycle, then timeout into sticky ERROR (stall counter saturates)
    reset_start();
    step(0, 0, 0, 0, 1, 0, 0, 1, MISS_O, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, WAIT_O, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, WAIT_O, 2, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, WAIT_O, 3, 0);
    step(0, 0, 0, 0, 1, 0, 1, 1, REL_O, 4, 0);
    none(RUN_O, 4, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, MISS_O, 4, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, WAIT_O, 5, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, WAIT_O, 6, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, WAIT_O, 7, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, WAIT_O, 7, 0);
    step(0, 1, 0, 0, 0, 0, 1, 1, ERR_O, 7, 0);
    step(0, 1, 1, 1, 1, 0, 0, 1, ERR_O, 7, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, IDLE_O, 0, 0);
    none(IDLE_O, 0, 0);

    // Stall counter saturation under a held load-use
    reset_start();
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 0, 0, 1, LU_O, (i < 7) ? i : 7, 0);
    none(RUN_O, 7, 0);

    // Flush counter saturation under a held taken branch
    reset_start();
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 0, 0, 1, BR_O, 0, (i < 7) ? i : 7);
    none(RUN_O, 0, 7);

    // Reset during MEM_WAIT with Ack in the same cycle
    reset_start();
    step(0, 0, 0, 0, 1, 0, 0, 1, MISS_O, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, WAIT_O, 1, 0);
    step(1, 0, 0, 0, 1, 0, 1, 0, REL_O, 2, 0);
    none(IDLE_O, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, IDLE_O, 0, 0);
    none(RUN_O, 0, 0);

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk_i);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
